// File: rtl/eth_tx_frame_arbiter_pkg.sv
// eth_arb_pkg: shared types and helpers for the TX frame arbiter and its round-robin picker.
//   state_t : arbiter FSM encoding (IDLE/PASS/ABORT/DRAIN, 2-bit)
//   clog2   : ceiling log2 usable in parameter expressions
package eth_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, ABORT = 2'd2, DRAIN = 2'd3} state_t;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/eth_tx_frame_arbiter_if.sv
// eth_tx_frame_arbiter_if: N_PORTS source AXI-stream lanes plus the single MAC-side AXI-stream.
//   s_axis_* : per-port source lanes, port k data at [8k+7:8k]
//   m_axis_* : shared MAC TX lane, tuser=1 on the last beat marks an aborted frame
//   slave    : arbiter view, master : source/MAC view
interface eth_tx_frame_arbiter_if #(parameter int N_PORTS = 4);
    logic [8*N_PORTS-1:0] s_axis_tdata;
    logic [N_PORTS-1:0]   s_axis_tvalid;
    logic [N_PORTS-1:0]   s_axis_tready;
    logic [N_PORTS-1:0]   s_axis_tlast;
    logic [7:0]           m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 m_axis_tlast;
    logic                 m_axis_tuser;
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser
    );
endinterface

// File: rtl/eth_tx_frame_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   req   : request vector
//   ptr   : index of the highest-priority requester this cycle
//   gnt   : one-hot winner, first set req at or above ptr (wrapping)
//   valid : any request present
module rr_pick import eth_arb_pkg::*; #(
    parameter  int N  = 4,
    localparam int PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);
    logic [PW-1:0] j;
    logic [PW-1:0] idx;
    // Scan from the farthest offset down so the nearest requester to ptr wins last.
    always_comb begin
        j     = '0;
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            j = PW'((int'(ptr) + i) % N);
            if (req[j]) begin
                idx   = j;
                valid = 1'b1;
            end
        end
        gnt = valid ? (N'(1) << idx) : '0;
    end
endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// eth_tx_frame_arbiter: frame-level round-robin arbiter sharing one MAC TX AXI-stream, with stall watchdog.
//   i_clk, rst : clock, synchronous active-high reset
//   bus        : source lanes and MAC lane (slave modport)
//   o_grant    : one-hot current owner, 0 when idle
//   o_busy     : high in any state except IDLE
//   o_timeout  : one-cycle pulse when a stalled frame is aborted
module eth_tx_frame_arbiter import eth_arb_pkg::*; #(
    parameter int N_PORTS        = 4,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic                   i_clk,
    input  logic                   rst,
    eth_tx_frame_arbiter_if.slave  bus,
    output logic [N_PORTS-1:0]     o_grant,
    output logic                   o_busy,
    output logic                   o_timeout
);
    localparam int PW = clog2(N_PORTS);
    localparam int CW = clog2(TIMEOUT_CYCLES + 1);

    state_t             state_q, state_d;
    logic [N_PORTS-1:0] grant_q, grant_d, pick_gnt;
    logic [PW-1:0]      ptr_q, ptr_d, k, ptr_nx;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               timeout_q, timeout_d, pick_valid, vld_k, last_k;

    rr_pick #(.N(N_PORTS)) u_pick (
        .req   (bus.s_axis_tvalid),
        .ptr   (ptr_q),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    always_comb begin
        k = '0;
        for (int i = 0; i < N_PORTS; i++) if (grant_q[i]) k = PW'(i);
    end

    assign vld_k  = |(bus.s_axis_tvalid & grant_q);
    assign last_k = |(bus.s_axis_tlast & grant_q);
    assign ptr_nx = (k == PW'(N_PORTS - 1)) ? '0 : k + 1'b1;

    always_ff @(posedge i_clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        cnt_d     = '0;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: if (pick_valid) begin
                state_d = PASS;
                grant_d = pick_gnt;
            end
            PASS: begin
                // Any presented beat, even one stalled by the MAC, restarts the watchdog.
                cnt_d = vld_k ? '0 : (cnt_q == CW'(TIMEOUT_CYCLES)) ? cnt_q : cnt_q + 1'b1;
                if (vld_k && bus.m_axis_tready && last_k) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = ptr_nx;
                end else if (!vld_k && cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = ABORT;
                    timeout_d = 1'b1;
                end
            end
            ABORT: if (bus.m_axis_tready) state_d = DRAIN;
            DRAIN: if (vld_k && last_k) begin
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = ptr_nx;
            end
            default: ;
        endcase
    end

    always_comb begin
        bus.m_axis_tdata  = (state_q == PASS) ? bus.s_axis_tdata[8*k +: 8] : '0;
        bus.m_axis_tvalid = (state_q == PASS) ? vld_k : (state_q == ABORT);
        bus.m_axis_tlast  = (state_q == PASS) ? last_k : (state_q == ABORT);
        bus.m_axis_tuser  = (state_q == ABORT);
        bus.s_axis_tready = (state_q == PASS) ? (bus.m_axis_tready ? grant_q : '0) :
                            (state_q == DRAIN) ? grant_q : '0;
    end

    assign o_grant   = grant_q;
    assign o_busy    = (state_q != IDLE);
    assign o_timeout = timeout_q;
endmodule
